// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter for one single-port RAM with lock/hold and a bounded hold time.
// Define RAM_ARB_RR_EN to resolve simultaneous idle requests round-robin instead of fixed m0 priority.
module ram_arbiter #(
  parameter int LockMax    = 16,
  parameter int MemAddrBus = 32,
  parameter int MemBus     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m1_req_i,
  input  logic                  m0_we_i,
  input  logic                  m1_we_i,
  input  logic [MemAddrBus-1:0] m0_addr_i,
  input  logic [MemAddrBus-1:0] m1_addr_i,
  input  logic [MemBus-1:0]     m0_wdata_i,
  input  logic [MemBus-1:0]     m1_wdata_i,
  input  logic                  m0_lock_i,
  input  logic                  m1_lock_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m1_rvalid_o,
  output logic [MemBus-1:0]     m0_rdata_o,
  output logic [MemBus-1:0]     m1_rdata_o,
  output logic                  ram_we_o,
  output logic [MemAddrBus-1:0] ram_addr_o,
  output logic [MemBus-1:0]     ram_wdata_o,
  input  logic [MemBus-1:0]     ram_rdata_i,
  output logic [1:0]            dbg_state_o
);
  // Handshake: a master holds req/we/addr/wdata stable until the cycle gnt is high;
  // that cycle is the access, and for a read rvalid/rdata follow one clock later.

  localparam int CntW = (LockMax > 1) ? $clog2(LockMax) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fav_q, fav_d;
  logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [MemBus-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              gnt0, gnt1, hold_done;

  // fav_q names the master that wins a contended arbitration in IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      LOCK0:   gnt0 = m0_req_i;
      LOCK1:   gnt1 = m1_req_i;
      default: begin
        if (m0_req_i && m1_req_i) begin
          gnt0 = ~fav_q;
          gnt1 = fav_q;
        end else begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i;
        end
      end
    endcase
  end

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt0) begin
      ram_we_o    = m0_we_i;
      ram_addr_o  = m0_addr_i;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt1) begin
      ram_we_o    = m1_we_i;
      ram_addr_o  = m1_addr_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  assign hold_done = (cnt_q == CntW'(LockMax - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fav_d   = fav_q;
`ifdef RAM_ARB_RR_EN
    if (gnt0)      fav_d = 1'b1;
    else if (gnt1) fav_d = 1'b0;
`else
    // The post-timeout favour is consumed by the first contended idle arbitration.
    if (state_q == IDLE && m0_req_i && m1_req_i) fav_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt0 && m0_lock_i)      state_d = LOCK0;
        else if (gnt1 && m1_lock_i) state_d = LOCK1;
      end
      LOCK0: begin
        cnt_d = cnt_q + CntW'(1);
        if (!m0_req_i || !m0_lock_i) begin
          state_d = IDLE;
        end else if (hold_done) begin
          state_d = IDLE;
          fav_d   = 1'b1;
        end
      end
      LOCK1: begin
        cnt_d = cnt_q + CntW'(1);
        if (!m1_req_i || !m1_lock_i) begin
          state_d = IDLE;
        end else if (hold_done) begin
          state_d = IDLE;
          fav_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    m0_rvalid_d = gnt0 & ~m0_we_i;
    m1_rvalid_d = gnt1 & ~m1_we_i;
    m0_rdata_d  = m0_rvalid_d ? ram_rdata_i : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_rdata_i : m1_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fav_q       <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fav_q       <= fav_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_ram_arbiter;
  localparam int LOCK_MAX = 16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, we, lock;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  wire  [1:0]  gnt, rvalid;
  wire  [31:0] rdata0, rdata1;
  wire         ram_we;
  wire  [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;
  wire  [1:0]  dbg_state;

  int checks = 0;
  int fails  = 0;

  ram_arbiter #(.LockMax(LOCK_MAX), .MemAddrBus(32), .MemBus(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(req[0]), .m1_req_i(req[1]),
    .m0_we_i(we[0]), .m1_we_i(we[1]),
    .m0_addr_i(addr[0]), .m1_addr_i(addr[1]),
    .m0_wdata_i(wdata[0]), .m1_wdata_i(wdata[1]),
    .m0_lock_i(lock[0]), .m1_lock_i(lock[1]),
    .m0_gnt_o(gnt[0]), .m1_gnt_o(gnt[1]),
    .m0_rvalid_o(rvalid[0]), .m1_rvalid_o(rvalid[1]),
    .m0_rdata_o(rdata0), .m1_rdata_o(rdata1),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset and the RAM the arbiter fronts
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram_mem [0:63];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr[7:2]] <= ram_wdata;
    end
  end
  assign ram_rdata = ram_mem[ram_addr[7:2]];

  // reference model: who holds the RAM, for how many cycles, who wins a tie
  int          mo_owner;
  int          mo_held;
  int          mo_fav;
  logic [31:0] mo_mem [0:63];
  logic [1:0]  mo_rv;
  logic [31:0] mo_rd [2];

  function automatic void model_reset();
    mo_owner = -1;
    mo_held  = 0;
    mo_fav   = 0;
    mo_rv    = 2'b00;
    mo_rd[0] = '0;
    mo_rd[1] = '0;
    for (int i = 0; i < 64; i++) mo_mem[i] = '0;
  endfunction

  function automatic int exp_grant();
    if (mo_owner >= 0) return req[mo_owner] ? mo_owner : -1;
    if (req[0] && req[1]) return mo_fav;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] gv(input int g);
    if (g == 0) return 2'b01;
    if (g == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_commit(input int g);
    bit both;
    both  = req[0] && req[1];
    mo_rv = 2'b00;
    if (g >= 0) begin
      if (we[g]) mo_mem[addr[g][7:2]] = wdata[g];
      else begin
        mo_rv[g] = 1'b1;
        mo_rd[g] = mo_mem[addr[g][7:2]];
      end
    end
`ifdef RAM_ARB_RR_EN
    if (g >= 0) mo_fav = 1 - g;
`else
    if (mo_owner < 0 && both) mo_fav = 0;
`endif
    if (mo_owner < 0) begin
      if (g >= 0 && lock[g]) begin
        mo_owner = g;
        mo_held  = 0;
      end
    end else begin
      mo_held++;
      if (!req[mo_owner] || !lock[mo_owner]) mo_owner = -1;
      else if (mo_held == LOCK_MAX) begin
        mo_fav   = 1 - mo_owner;
        mo_owner = -1;
      end
    end
  endfunction

  // driver tasks
  task automatic drive(input int n, input bit r, input bit w, input bit l,
                       input logic [31:0] a, input logic [31:0] d);
    req[n]   = r;
    we[n]    = w;
    lock[n]  = l;
    addr[n]  = a;
    wdata[n] = d;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
  endtask

  task automatic sample(output int g);
    @(negedge clk);
    g = exp_grant();
  endtask

  task automatic advance(input int g);
    @(posedge clk);
    model_commit(g);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    int g;
    drive_idle();
    repeat (n) begin
      sample(g);
      advance(g);
    end
  endtask

  // scenarios
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b00 || gnt !== 2'b00) begin
      fails++;
      $display("FAIL reset_handshake: rvalid=%b gnt=%b expected 00 00", rvalid, gnt);
    end
    checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0, rdata1);
    end
    checks++;
    if (dbg_state !== 2'd0 || ram_we !== 1'b0 || ram_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_idle: state=%0d ram_we=%b ram_addr=%h expected 0 0 0", dbg_state, ram_we, ram_addr);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    int g;
    for (int c = 0; c < 3; c++) begin
      drive_idle();
      if (c == 0) drive(0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
      if (c == 1) drive(0, 1, 0, 0, 32'h10, 32'h0);
      sample(g);
      checks++;
      if (c < 2 && gnt !== 2'b01) begin
        fails++;
        $display("FAIL wr_rd_gnt c%0d: gnt=%b expected 01", c, gnt);
      end
      checks++;
      if (rvalid !== {1'b0, c == 2} || (c == 2 && rdata0 !== 32'hDEADBEEF)) begin
        fails++;
        $display("FAIL wr_rd_rvalid c%0d: rvalid=%b rdata=%h expected %b DEADBEEF", c, rvalid, rdata0, {1'b0, c == 2});
      end
      advance(g);
    end
  endtask

  task automatic test_contention();
    int g;
    int prev_g = -1;
    drive(0, 1, 0, 0, 32'($urandom_range(0, 15)) << 2, '0);
    drive(1, 1, 0, 0, 32'($urandom_range(0, 15)) << 2, '0);
    for (int c = 0; c < 8; c++) begin
      sample(g);
      checks++;
      if (gnt !== gv(g)) begin
        fails++;
        $display("FAIL contend_gnt c%0d: gnt=%b expected %b", c, gnt, gv(g));
      end
`ifdef RAM_ARB_RR_EN
      checks++;
      if (c > 0 && gnt !== ~gv(prev_g)) begin
        fails++;
        $display("FAIL contend_alternate c%0d: gnt=%b expected %b", c, gnt, ~gv(prev_g));
      end
`else
      checks++;
      if (gnt !== 2'b01) begin
        fails++;
        $display("FAIL contend_fixed c%0d: gnt=%b expected 01", c, gnt);
      end
`endif
      checks++;
      if (c > 0 && (rvalid !== gv(prev_g) || rdata0 !== mo_rd[0] || rdata1 !== mo_rd[1])) begin
        fails++;
        $display("FAIL contend_rvalid c%0d: rvalid=%b expected %b", c, rvalid, gv(prev_g));
      end
      advance(g);
      if (g >= 0) addr[g] = 32'($urandom_range(0, 15)) << 2;
      prev_g = g;
    end
    idle_cycles(2);
  endtask

  task automatic test_lock_stall();
    int g;
    for (int c = 0; c < 6; c++) begin
      drive(0, c >= 1, 0, 0, 32'h24, '0);
      drive(1, c < 5, 0, c < 4, 32'h20, '0);
      sample(g);
      checks++;
      if (gnt !== gv(g) || gnt[0] !== (c == 5)) begin
        fails++;
        $display("FAIL lock_stall c%0d: gnt=%b expected %b", c, gnt, gv(g));
      end
      checks++;
      if (rvalid !== mo_rv) begin
        fails++;
        $display("FAIL lock_stall_rvalid c%0d: rvalid=%b expected %b", c, rvalid, mo_rv);
      end
      advance(g);
    end
    idle_cycles(2);
  endtask

  task automatic test_lock_timeout(input int h);
    int  g;
    int  held = 0;
    bit  other_won = 0;
    drive_idle();
    drive(h, 1, 0, 1, 32'h30, '0);
    sample(g);
    advance(g);
    drive(1 - h, 1, 0, 0, 32'h34, '0);
    for (int c = 0; c < 3 * LOCK_MAX && !other_won; c++) begin
      sample(g);
      checks++;
      if (gnt !== gv(g)) begin
        fails++;
        $display("FAIL timeout_gnt h%0d c%0d: gnt=%b expected %b", h, c, gnt, gv(g));
      end
      if (gnt[1 - h]) other_won = 1;
      else if (gnt[h]) held++;
      advance(g);
    end
    checks++;
    if (!other_won || held !== LOCK_MAX) begin
      fails++;
      $display("FAIL timeout_release h%0d: waiter_granted=%0d hold_cycles=%0d expected 1 %0d", h, other_won, held, LOCK_MAX);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_lock();
    int g;
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, 0, 1, 32'(c) << 2, '0);
      sample(g);
      if (c == 0) advance(g);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rvalid !== 2'b00 || dbg_state !== 2'd0 || rdata0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_lock: rvalid=%b state=%0d rdata0=%h expected 00 0 0", rvalid, dbg_state, rdata0);
    end
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1, 0, 0, 32'h8, '0);
    drive(1, 1, 0, 0, 32'hC, '0);
    sample(g);
    checks++;
    if (gnt !== 2'b01 || gnt !== gv(g)) begin
      fails++;
      $display("FAIL post_reset_contend: gnt=%b expected 01", gnt);
    end
    advance(g);
    drive(0, 0, 0, 0, '0, '0);
    sample(g);
    advance(g);
    idle_cycles(2);
  endtask

  task automatic test_random();
    int         g;
    logic [1:0] last_g = 2'b00;
    logic [1:0] eg;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(req[n] && !last_g[n])) begin
          drive(n, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                32'($urandom_range(0, 15)) << 2, $urandom);
        end
      end
      sample(g);
      eg = gv(g);
      checks++;
      if (gnt !== eg) begin
        fails++;
        $display("FAIL rand_gnt c%0d: gnt=%b expected %b", c, gnt, eg);
      end
      checks++;
      if (rvalid !== mo_rv || rdata0 !== mo_rd[0] || rdata1 !== mo_rd[1]) begin
        fails++;
        $display("FAIL rand_read c%0d: rvalid=%b rdata=%h/%h expected %b %h/%h",
                 c, rvalid, rdata0, rdata1, mo_rv, mo_rd[0], mo_rd[1]);
      end
      checks++;
      if (g < 0 && (ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0)) begin
        fails++;
        $display("FAIL rand_ram_idle c%0d: we=%b addr=%h wdata=%h expected 0 0 0", c, ram_we, ram_addr, ram_wdata);
      end else if (g >= 0 && (ram_we !== we[g] || ram_addr !== addr[g] || ram_wdata !== wdata[g])) begin
        fails++;
        $display("FAIL rand_ram_port c%0d: we=%b addr=%h wdata=%h expected %b %h %h",
                 c, ram_we, ram_addr, ram_wdata, we[g], addr[g], wdata[g]);
      end
      advance(g);
      last_g = eg;
    end
    idle_cycles(3);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_contention();
    test_lock_stall();
    test_lock_timeout(1);
    test_lock_timeout(0);
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
